uimac_pause_gen: RTL and testbench

UIMAC_PAUSE_GEN -- requirements
Module: uimac_pause_gen

---
 rtl/uimac_pause_gen_pkg.sv | 52 +++++
 rtl/uicrc32_d8.sv | 21 ++
 rtl/uimac_pause_gen.sv | 148 ++++++++++++++
 tb/tb_uimac_pause_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uimac_pause_gen_pkg.sv
// Shared constants, FSM encoding and per-byte helpers for the PAUSE frame generator.
package uimac_pause_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_PRE,
      ST_DATA,
      ST_FCS,
      ST_IFG
   } state_t;

   localparam logic [47:0] PAUSE_DA       = 48'h0180C2000001;
   localparam logic [15:0] ETH_TYPE_PAUSE = 16'h8808;
   localparam logic [15:0] PAUSE_OPCODE   = 16'h0001;

   localparam int unsigned PRE_LEN   = 8;
   localparam int unsigned DATA_LEN  = 60;
   localparam int unsigned FCS_LEN   = 4;
   localparam int unsigned FRAME_LEN = PRE_LEN + DATA_LEN + FCS_LEN;
   localparam int unsigned HDR_LEN   = 18;

   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

   // Byte idx (0..59) of the DA..pad region; everything past the header is zero padding.
   function automatic logic [7:0] pause_data_byte(input logic [5:0] idx,
                                                  input logic [47:0] sa,
                                                  input logic [15:0] quanta);
      logic [143:0] hdr;
      int unsigned  i;
      i   = 32'(idx);
      hdr = {PAUSE_DA, sa, ETH_TYPE_PAUSE, PAUSE_OPCODE, quanta};
      if (i < HDR_LEN) begin
         hdr = hdr << (8 * i);
         return hdr[143:136];
      end
      return 8'h00;
   endfunction

   // Reflected CRC-32 update, one byte, LSB first.
   function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc,
                                                 input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int b = 0; b < 8; b++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/uicrc32_d8.sv
// Byte-wide Ethernet CRC-32 accumulator; init presets, enable folds in one byte.
module uicrc32_d8
   import uimac_pause_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        init,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   always_ff @(posedge clk) begin
      if (reset || init) begin
         crc <= CRC_INIT;
      end else if (enable) begin
         crc <= crc32_d8_next(crc, data);
      end
   end

endmodule

// File: rtl/uimac_pause_gen.sv
// 802.3x PAUSE frame generator: watches receive-buffer fill with hysteresis and
// emits XOFF/XON frames (preamble..FCS) on the GMII lane once granted.
module uimac_pause_gen
   import uimac_pause_gen_pkg::*;
#(
   parameter logic [15:0] PAUSE_QUANTA    = 16'hFFFF,
   parameter logic [7:0]  XOFF_TH         = 8'd192,
   parameter logic [7:0]  XON_TH          = 8'd64,
   parameter logic [23:0] REFRESH_CYCLES  = 24'd3_000_000,
   parameter logic [3:0]  INTER_FRAME_GAP = 4'd12
) (
   input  logic        I_gmii_tclk,
   input  logic        I_mac_reset,
   input  logic [47:0] I_mac_local_addr,
   input  logic [7:0]  I_rfifo_level,
   output logic        O_pause_req,
   input  logic        I_pause_gnt,
   output logic        O_gmii_tvalid,
   output logic [7:0]  O_gmii_tdata,
   output logic        O_pause_busy,
   output logic        O_xoff_active
);

   localparam logic [6:0]  DATA_START  = 7'(PRE_LEN);
   localparam logic [6:0]  FCS_START   = 7'(PRE_LEN + DATA_LEN);
   localparam logic [6:0]  LAST_IDX    = 7'(FRAME_LEN - 1);
   localparam logic [23:0] REFRESH_MAX = REFRESH_CYCLES - 24'd1;

   state_t      state;
   logic [15:0] quanta;
   logic [47:0] sa;
   logic [6:0]  byte_cnt;
   logic [23:0] refresh_cnt;
   logic [31:0] crc;
   logic [31:0] fcs;
   logic [1:0]  fcs_sel;
   logic [6:0]  nxt_idx;
   logic [7:0]  nxt_byte;
   logic        crc_en;
   logic        crc_init;

   // Byte that goes on the wire at the next edge; byte_cnt is the one currently shown.
   always_comb begin
      nxt_idx  = byte_cnt + 7'd1;
      fcs      = ~crc;
      fcs_sel  = 2'(nxt_idx - FCS_START);
      nxt_byte = 8'h55;
      if (nxt_idx == DATA_START - 7'd1) begin
         nxt_byte = 8'hD5;
      end else if (nxt_idx >= DATA_START && nxt_idx < FCS_START) begin
         nxt_byte = pause_data_byte(6'(nxt_idx - DATA_START), sa, quanta);
      end else if (nxt_idx >= FCS_START) begin
         nxt_byte = 8'(fcs >> {fcs_sel, 3'b000});
      end
      crc_init = (state == ST_REQ) && I_pause_gnt;
      crc_en   = (state == ST_PRE || state == ST_DATA) &&
                 nxt_idx >= DATA_START && nxt_idx < FCS_START;
   end

   uicrc32_d8 u_crc (
      .clk    (I_gmii_tclk),
      .reset  (I_mac_reset),
      .enable (crc_en),
      .init   (crc_init),
      .data   (nxt_byte),
      .crc    (crc)
   );

   always_ff @(posedge I_gmii_tclk) begin
      if (I_mac_reset) begin
         state         <= ST_IDLE;
         quanta        <= 16'h0000;
         sa            <= 48'h0;
         byte_cnt      <= 7'd0;
         refresh_cnt   <= 24'd0;
         O_pause_req   <= 1'b0;
         O_gmii_tvalid <= 1'b0;
         O_gmii_tdata  <= 8'h00;
         O_pause_busy  <= 1'b0;
         O_xoff_active <= 1'b0;
      end else begin
         if (O_xoff_active && refresh_cnt != REFRESH_MAX) begin
            refresh_cnt <= refresh_cnt + 24'd1;
         end
         case (state)
            // XON beats refresh; XOFF and XON are exclusive through xoff_active.
            ST_IDLE: begin
               if (O_xoff_active && I_rfifo_level <= XON_TH) begin
                  state         <= ST_REQ;
                  quanta        <= 16'h0000;
                  O_xoff_active <= 1'b0;
                  O_pause_req   <= 1'b1;
                  refresh_cnt   <= 24'd0;
               end else if (!O_xoff_active && I_rfifo_level >= XOFF_TH) begin
                  state         <= ST_REQ;
                  quanta        <= PAUSE_QUANTA;
                  O_xoff_active <= 1'b1;
                  O_pause_req   <= 1'b1;
                  refresh_cnt   <= 24'd0;
               end else if (O_xoff_active && refresh_cnt == REFRESH_MAX) begin
                  state         <= ST_REQ;
                  quanta        <= PAUSE_QUANTA;
                  O_pause_req   <= 1'b1;
                  refresh_cnt   <= 24'd0;
               end
            end
            ST_REQ: begin
               if (I_pause_gnt) begin
                  state         <= ST_PRE;
                  sa            <= I_mac_local_addr;
                  byte_cnt      <= 7'd0;
                  O_pause_req   <= 1'b0;
                  O_pause_busy  <= 1'b1;
                  O_gmii_tvalid <= 1'b1;
                  O_gmii_tdata  <= 8'h55;
               end
            end
            ST_PRE, ST_DATA, ST_FCS: begin
               if (byte_cnt == LAST_IDX) begin
                  state         <= ST_IFG;
                  byte_cnt      <= 7'd0;
                  O_gmii_tvalid <= 1'b0;
                  O_gmii_tdata  <= 8'h00;
               end else begin
                  byte_cnt     <= nxt_idx;
                  O_gmii_tdata <= nxt_byte;
                  if (nxt_idx == DATA_START) begin
                     state <= ST_DATA;
                  end else if (nxt_idx == FCS_START) begin
                     state <= ST_FCS;
                  end
               end
            end
            ST_IFG: begin
               if (nxt_idx >= 7'(INTER_FRAME_GAP)) begin
                  state        <= ST_IDLE;
                  byte_cnt     <= 7'd0;
                  O_pause_busy <= 1'b0;
               end else begin
                  byte_cnt <= nxt_idx;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uimac_pause_gen.sv
// Directed bench for uimac_pause_gen: cycle vector table plus frame-level sequences.
module tb_uimac_pause_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [47:0] mac;
   logic [47:0] exp_mac;
   logic [7:0]  lvl;
   logic        gnt;
   logic        O_pause_req;
   logic        O_gmii_tvalid;
   logic [7:0]  O_gmii_tdata;
   logic        O_pause_busy;
   logic        O_xoff_active;

   int unsigned nvec = 0;
   int unsigned nerr = 0;
   int unsigned cyc = 0;
   int unsigned rise_cyc = 0;
   int unsigned prev_rise = 0;
   logic [7:0]  cap [0:127];

   typedef struct {
      logic       rst;
      logic [7:0] lvl;
      logic       gnt;
      logic       req;
      logic       valid;
      logic       busy;
      logic       xoff;
      logic [7:0] data;
   } vec_t;

   localparam int NV = 14;
   vec_t tbl [0:NV-1];

   uimac_pause_gen #(
      .PAUSE_QUANTA    (16'hFFFF),
      .XOFF_TH         (8'd192),
      .XON_TH          (8'd64),
      .REFRESH_CYCLES  (24'd1000),
      .INTER_FRAME_GAP (4'd12)
   ) dut (
      .I_gmii_tclk      (clk),
      .I_mac_reset      (rst),
      .I_mac_local_addr (mac),
      .I_rfifo_level    (lvl),
      .O_pause_req      (O_pause_req),
      .I_pause_gnt      (gnt),
      .O_gmii_tvalid    (O_gmii_tvalid),
      .O_gmii_tdata     (O_gmii_tdata),
      .O_pause_busy     (O_pause_busy),
      .O_xoff_active    (O_xoff_active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int i, input logic [15:0] q);
      logic [7:0] da [0:5];
      int j;
      da = '{8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h01};
      if (i < 7) return 8'h55;
      if (i == 7) return 8'hD5;
      j = i - 8;
      if (j < 6) return da[j];
      if (j < 12) return 8'(exp_mac >> (8 * (11 - j)));
      case (j)
         12: return 8'h88;
         13: return 8'h08;
         14: return 8'h00;
         15: return 8'h01;
         16: return q[15:8];
         17: return q[7:0];
         default: return 8'h00;
      endcase
   endfunction

   // Receiver-side CRC (MSB-first register, bits fed LSB first) over DA..FCS.
   function automatic logic [31:0] rx_residue(input int n);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFFFFFF;
      for (int i = 8; i < n && i < 128; i++) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[31] ^ cap[i][b];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C11DB7;
         end
      end
      return c;
   endfunction

   task automatic wait_req(input int bound, input string name);
      int k = 0;
      while (O_pause_req !== 1'b1 && k < bound) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(O_pause_req), 32'd1);
      rise_cyc = cyc;
   endtask

   task automatic run_frame(input logic [15:0] q, input int drop_at, input string tag);
      int n = 0;
      int g = 0;
      logic [47:0] keep;
      keep    = mac;
      exp_mac = mac;
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      mac = ~keep;
      check({tag, "_first_valid"}, 32'(O_gmii_tvalid), 32'd1);
      while (O_gmii_tvalid === 1'b1 && n < 100) begin
         cap[n] = O_gmii_tdata;
         n++;
         if (n == drop_at) lvl = 8'd30;
         @(negedge clk);
      end
      check({tag, "_len"}, 32'(n), 32'd72);
      check({tag, "_idle_data"}, 32'(O_gmii_tdata), 32'd0);
      for (int i = 0; i < 68 && i < n; i++) begin
         check($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp_byte(i, q)));
      end
      check({tag, "_residue"}, rx_residue(n), 32'hC704DD7B);
      while (O_pause_busy === 1'b1 && O_gmii_tvalid === 1'b0 && g < 50) begin
         g++;
         @(negedge clk);
      end
      check({tag, "_ifg"}, 32'(g), 32'd12);
      check({tag, "_post_valid"}, 32'(O_gmii_tvalid), 32'd0);
      check({tag, "_post_busy"}, 32'(O_pause_busy), 32'd0);
      mac = keep;
   endtask

   initial begin
      int n;
      mac     = 48'h021A2B3C4D5E;
      exp_mac = mac;
      rst = 1'b1;
      lvl = 8'd0;
      gnt = 1'b0;

      //            rst  lvl     gnt  req  vld  busy xoff data
      tbl[0]  = '{1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 8'd100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[3]  = '{1'b0, 8'd191, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[4]  = '{1'b0, 8'd64,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[5]  = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[6]  = '{1'b0, 8'd192, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[7]  = '{1'b0, 8'd30,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[8]  = '{1'b0, 8'd30,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55};
      tbl[9]  = '{1'b0, 8'd30,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55};
      tbl[10] = '{1'b0, 8'd30,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55};
      tbl[11] = '{1'b1, 8'd30,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[12] = '{1'b0, 8'd30,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[13] = '{1'b0, 8'd150, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

      for (int i = 0; i < NV; i++) begin
         rst = tbl[i].rst;
         lvl = tbl[i].lvl;
         gnt = tbl[i].gnt;
         @(negedge clk);
         check($sformatf("v%0d_req", i),   32'(O_pause_req),   32'(tbl[i].req));
         check($sformatf("v%0d_valid", i), 32'(O_gmii_tvalid), 32'(tbl[i].valid));
         check($sformatf("v%0d_busy", i),  32'(O_pause_busy),  32'(tbl[i].busy));
         check($sformatf("v%0d_xoff", i),  32'(O_xoff_active), 32'(tbl[i].xoff));
         check($sformatf("v%0d_data", i),  32'(O_gmii_tdata),  32'(tbl[i].data));
      end
      rst = 1'b0;
      gnt = 1'b0;

      // XOFF request, grant withheld, then the first frame.
      lvl = 8'd0;
      @(negedge clk);
      lvl = 8'd200;
      wait_req(2, "b_xoff_req");
      prev_rise = rise_cyc;
      check("b_xoff_active", 32'(O_xoff_active), 32'd1);
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         check("b_hold_req",   32'(O_pause_req),   32'd1);
         check("b_hold_valid", 32'(O_gmii_tvalid), 32'd0);
         check("b_hold_busy",  32'(O_pause_busy),  32'd0);
         check("b_hold_data",  32'(O_gmii_tdata),  32'd0);
      end
      run_frame(16'hFFFF, -1, "b_xoff");
      check("b_xoff_after", 32'(O_xoff_active), 32'd1);

      // Refresh re-send, hysteresis band, then XON.
      wait_req(1100, "c_refresh_req");
      check("c_refresh_interval", 32'(rise_cyc - prev_rise), 32'd1000);
      run_frame(16'hFFFF, -1, "c_refresh");
      for (int k = 0; k < 50; k++) begin
         lvl = (k % 2 == 1) ? 8'd65 : 8'd191;
         @(negedge clk);
         check("c_hyst_req", 32'(O_pause_req), 32'd0);
      end
      lvl = 8'd30;
      wait_req(2, "c_xon_req");
      check("c_xon_clear", 32'(O_xoff_active), 32'd0);
      run_frame(16'h0000, -1, "c_xon");

      // Level falls mid-XOFF frame: frame unchanged, XON right after the gap.
      lvl = 8'd200;
      wait_req(2, "d_xoff_req");
      run_frame(16'hFFFF, 20, "d_xoff");
      check("d_gap_req", 32'(O_pause_req), 32'd0);
      check("d_gap_xoff", 32'(O_xoff_active), 32'd1);
      wait_req(2, "d_xon_req");
      check("d_xon_clear", 32'(O_xoff_active), 32'd0);
      run_frame(16'h0000, -1, "d_xon");

      // Reset at byte 30 truncates the frame.
      lvl = 8'd200;
      wait_req(2, "e_xoff_req");
      gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      n = 0;
      while (O_gmii_tvalid === 1'b1 && n < 30) begin
         n++;
         @(negedge clk);
      end
      check("e_byte30_valid", 32'(O_gmii_tvalid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("e_rst_valid", 32'(O_gmii_tvalid), 32'd0);
      check("e_rst_data",  32'(O_gmii_tdata),  32'd0);
      check("e_rst_busy",  32'(O_pause_busy),  32'd0);
      check("e_rst_req",   32'(O_pause_req),   32'd0);
      check("e_rst_xoff",  32'(O_xoff_active), 32'd0);
      rst = 1'b0;
      lvl = 8'd100;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("e_quiet_valid", 32'(O_gmii_tvalid), 32'd0);
         check("e_quiet_req",   32'(O_pause_req),   32'd0);
      end
      lvl = 8'd200;
      wait_req(2, "e_new_req");
      check("e_new_xoff", 32'(O_xoff_active), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
